// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions used by the instruction fetch front end.
// Defines the word widths, the reset fetch address and the queue entry layout.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue of {pc, inst} entries with push, pop, flush and occupancy.
// A flush wins over a same-cycle push; the pop in that cycle is simply absorbed.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  fetch_entry_t               i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output fetch_entry_t               o_rdata,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_full;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !i_flush;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(i_pop && o_empty));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request stream into a small queue feeding decode.
// Redirects flush the queue and restart fetching at the (word-aligned) target.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic [ILEN-1:0]        imem_rdata,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [ILEN-1:0]        dec_inst,
  output logic [XLEN-1:0]        dec_pc,
  output logic [XLEN-1:0]        dec_pc4,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] r_fetch_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_squash;

  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occ;
  fetch_entry_t    w_entry;
  fetch_entry_t    w_head;

  // Occupancy counts the response already in flight so the queue can never overflow.
  assign w_occ     = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_req     = !rst && !redirect && (w_occ < (CW+1)'(DEPTH));
  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;

  assign w_push    = !rst && !redirect && r_inflight && !r_squash;
  assign w_entry   = '{pc: r_inflight_pc, inst: imem_rdata};

  assign dec_valid = !rst && !w_empty;
  assign w_pop     = dec_valid && dec_ready;
  assign dec_inst  = w_head.inst;
  assign dec_pc    = w_head.pc;
  assign dec_pc4   = w_head.pc + XLEN'(4);
  assign q_count   = rst ? '0 : w_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= align_word(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_squash      <= 1'b0;
    end else begin
      r_inflight <= w_req;
      r_squash   <= redirect;
      if (redirect) begin
        r_fetch_pc <= align_word(redirect_pc);
      end else if (w_req) begin
        r_fetch_pc    <= r_fetch_pc + XLEN'(4);
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_pop   (w_pop),
    .i_flush (redirect && !rst),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction queue entries; power of two, minimum 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port imem_req, output, 1 bit: instruction memory read request this cycle.
REQ-006 SHALL have port imem_addr, output, 32 bits: byte address of the request; bits [1:0] always 0.
REQ-007 SHALL have port imem_rdata, input, 32 bits: instruction word, valid exactly one cycle after imem_req.
REQ-008 SHALL have port redirect, input, 1 bit: taken branch, JAL, JALR or trap from execute.
REQ-009 SHALL have port redirect_pc, input, 32 bits: new fetch address when redirect=1.
REQ-010 SHALL have port dec_valid, output, 1 bit: queue head holds a valid instruction.
REQ-011 SHALL have port dec_ready, input, 1 bit: decode accepts the head this cycle.
REQ-012 SHALL have port dec_inst, output, 32 bits: head instruction word.
REQ-013 SHALL have port dec_pc, output, 32 bits: address of the head instruction.
REQ-014 SHALL have port dec_pc4, output, 32 bits: dec_pc + 4, modulo 2^32.
REQ-015 SHALL have port q_count, output, $clog2(DEPTH)+1 bits: current queue occupancy, for debug.

Function
REQ-016 SHALL hold fetch_pc, inflight flag, inflight_pc and squash flag as registered state.
REQ-017 SHALL drive imem_req=1 when not rst and (q_count + inflight) < DEPTH; occupancy is taken before the same-cycle pop.
REQ-018 SHALL drive imem_addr = fetch_pc; on each issued request, fetch_pc <= fetch_pc + 4, wrapping 32'hFFFF_FFFC to 0.
REQ-019 SHALL, on an issued request, set inflight=1 and inflight_pc=fetch_pc; the response is pushed at the end of the next cycle unless squashed.
REQ-020 SHALL provide a first-instruction latency of 2 cycles, request to dec_valid, with no bypass path.
REQ-021 SHALL sustain one instruction per cycle when dec_ready is held at 1 and no redirect occurs.
REQ-022 SHALL pop the head on dec_valid & dec_ready; a same-cycle push and pop leaves q_count unchanged.
REQ-023 SHALL never push into a full queue or pop an empty one; the credit rule of REQ-017 guarantees this, and an assertion checks it.
REQ-024 SHALL, on redirect=1, take the following actions in that cycle: flush the queue (q_count <= 0), squash any response due next cycle, set fetch_pc <= {redirect_pc[31:2], 2'b00}, and suppress imem_req.
REQ-025 SHALL give redirect priority over a same-cycle pop and push; the popped instruction counts as consumed, and the pushed one is discarded.
REQ-026 SHALL keep dec_valid=0 in the cycle after a redirect; the first redirected instruction appears 3 cycles after redirect assertion.
REQ-027 SHALL present dec_inst, dec_pc and dec_pc4 stable while dec_valid=1 and dec_ready=0.

Reset
REQ-028 SHALL, while rst=1, set fetch_pc=RESET_PC, q_count=0, inflight=0, squash=0, dec_valid=0 and imem_req=0; redirect is ignored.
REQ-029 SHALL discard a response arriving in the cycle after reset when reset is asserted mid-operation.
REQ-030 SHALL issue the first request, to RESET_PC, in the first cycle with rst=0.

Structure
REQ-031 SHALL take RESET_PC default, XLEN=32 and the instruction width from the shared processor package.
REQ-032 SHALL instantiate one sub-module, fetch_fifo: a DEPTH x 64-bit {pc, inst} circular buffer with push, pop, flush and count.

Verification
REQ-033 SHALL cover reset release with dec_ready=1: imem_addr reads 0, 4, 8 on consecutive cycles, and dec_pc=0 with dec_inst=mem[0] two cycles after the first request.
REQ-034 SHALL cover dec_ready=0 for 10 cycles: q_count saturates at 4, imem_req drops, and the head stays stable; on release, 4 pops on consecutive cycles in order.
REQ-035 SHALL cover redirect to 32'h0000_0102 with a request in flight: the in-flight word is never presented, imem_addr becomes 32'h100, and dec_pc=32'h100 three cycles later.
REQ-036 SHALL cover redirect coinciding with a pop and a push: q_count=0 next cycle, and no stale instruction appears.
REQ-037 SHALL cover a wrap case: with RESET_PC=32'hFFFF_FFF8, the fetched addresses are FFFF_FFF8, FFFF_FFFC, 0000_0000, and dec_pc4 of FFFF_FFFC is 0.
REQ-038 SHALL cover rst asserted for 1 cycle mid-stream: the queue empties, and the next dec_pc equals RESET_PC.
